det_event_encoder: RTL and testbench

- Sink for the 10-lane photon-detection vector `det[9:0]` produced by the phase-window edge detectors in the `clk_out` domain.
- Each cycle with any `det` bit set becomes one timestamped event word:
  - bin index of the earliest (lowest) set window;
  - multi-hit flag;
  - free-running timestamp.
- Event words are buffered in a FIFO and read out over a valid/ready stream.
- Per-bin hit counters run alongside for rate monitoring.

---
 rtl/det_event_encoder.sv | 237 +++++++++++++++++++++++
 tb/tb_det_event_encoder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/det_event_encoder.sv
// det_event_encoder
// Turns the per-window detection vector into timestamped event words
// {marker, multi, bin[3:0], ts}, queues them in a first-word-fall-through
// FIFO read over valid/ready, and keeps a saturating hit counter per bin.
// Optional build macro: DET_EVENT_ROLLOVER_MARKER_EN queues a marker word
// {1,0,4'hF,ts=0} every time the timestamp rolls over to zero.
module det_event_encoder #(
  parameter int NBINS      = 10,
  parameter int TS_W       = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                          clk_out,
  input  logic                          reset_n,
  input  logic [NBINS-1:0]              det,
  input  logic                          enable,
  input  logic                          clear,
  output logic [TS_W+5:0]               ev_data,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic [3:0]                    cnt_sel,
  output logic [CNT_W-1:0]              cnt_value
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = TS_W + 6;

  // Index of the lowest set lane (earliest window).
  function automatic logic [3:0] lowest_set(input logic [NBINS-1:0] vec);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = NBINS - 1; i >= 0; i--) begin
      idx = vec[i] ? 4'(i) : idx;
    end
    return idx;
  endfunction

  // True when two or more lanes are set: clearing the lowest bit leaves some bit set.
  function automatic logic is_multi(input logic [NBINS-1:0] vec);
    return ((vec & (vec - NBINS'(1))) != {NBINS{1'b0}});
  endfunction

  logic [TS_W-1:0]  ts_r;
  logic             s1_valid_r;
  logic [EW-1:0]    s1_word_r;
  logic [EW-1:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    count_r;
  logic [EW-1:0]    head_r;
  logic             valid_r;
  logic             overflow_r;
  logic [CNT_W-1:0] cnt_r [NBINS];
  logic [CNT_W-1:0] cnt_value_r;

  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             accept_s;
  logic             drop_s;
  logic             mk_lost_s;
  logic [EW-1:0]    wdata_s;
  logic [EW-1:0]    head_nxt_s;
  logic [AW-1:0]    rd_nxt_s;
  logic [AW-1:0]    wr_nxt_s;
  logic [LW-1:0]    count_nxt_s;
  logic [CNT_W-1:0] sel_cnt_s;

  // Free-running timestamp, wraps naturally at all-ones.
  always_ff @(posedge clk_out or negedge reset_n) begin
    if (!reset_n) begin
      ts_r <= {TS_W{1'b0}};
    end else begin
      ts_r <= ts_r + TS_W'(1);
    end
  end

  // Stage 1: capture the event word in the cycle det is sampled.
  always_ff @(posedge clk_out or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_r <= 1'b0;
      s1_word_r  <= {EW{1'b0}};
    end else begin
      s1_valid_r <= enable & (det != {NBINS{1'b0}});
      s1_word_r  <= {1'b0, is_multi(det), lowest_set(det), ts_r};
    end
  end

`ifdef DET_EVENT_ROLLOVER_MARKER_EN
  localparam logic [EW-1:0] MARKER_WORD = {1'b1, 1'b0, 4'hF, {TS_W{1'b0}}};

  logic wrap_r;
  logic mk_pend_r;
  logic mk_pend_nxt_s;

  // Rollover flag (high in the ts==0 cycle after a wrap) and pending marker.
  always_ff @(posedge clk_out or negedge reset_n) begin
    if (!reset_n) begin
      wrap_r    <= 1'b0;
      mk_pend_r <= 1'b0;
    end else begin
      wrap_r    <= (ts_r == {TS_W{1'b1}});
      mk_pend_r <= mk_pend_nxt_s;
    end
  end

  // Stage-2 write slot: a detector event wins; a marker waits for a free slot.
  always_comb begin
    push_s        = 1'b0;
    wdata_s       = s1_word_r;
    mk_pend_nxt_s = 1'b0;
    mk_lost_s     = wrap_r & mk_pend_r;
    if (s1_valid_r) begin
      push_s        = 1'b1;
      mk_pend_nxt_s = wrap_r | mk_pend_r;
    end else if (wrap_r | mk_pend_r) begin
      push_s  = 1'b1;
      wdata_s = MARKER_WORD;
    end else begin
      push_s = 1'b0;
    end
  end
`else
  // Stage-2 write slot carries detector events only.
  always_comb begin
    push_s    = s1_valid_r;
    wdata_s   = s1_word_r;
    mk_lost_s = 1'b0;
  end
`endif

  // FIFO next-state: push accepted when not full or when a pop frees a slot.
  always_comb begin
    pop_s    = valid_r & ev_ready;
    full_s   = (count_r == LW'(FIFO_DEPTH));
    accept_s = push_s & (~full_s | pop_s);
    drop_s   = push_s & full_s & ~pop_s;
    rd_nxt_s = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
    wr_nxt_s = accept_s ? (wr_ptr_r + AW'(1)) : wr_ptr_r;
    case ({accept_s, pop_s})
      2'b10:   count_nxt_s = count_r + LW'(1);
      2'b01:   count_nxt_s = count_r - LW'(1);
      default: count_nxt_s = count_r;
    endcase
    if (count_nxt_s == {LW{1'b0}}) begin
      head_nxt_s = {EW{1'b0}};
    end else if (accept_s && (wr_ptr_r == rd_nxt_s)) begin
      head_nxt_s = wdata_s;
    end else begin
      head_nxt_s = mem_r[rd_nxt_s];
    end
  end

  // FIFO storage, pointers and registered head word / status.
  always_ff @(posedge clk_out or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {EW{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {LW{1'b0}};
      head_r   <= {EW{1'b0}};
      valid_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        mem_r[wr_ptr_r] <= wdata_s;
      end
      wr_ptr_r <= wr_nxt_s;
      rd_ptr_r <= rd_nxt_s;
      count_r  <= count_nxt_s;
      head_r   <= head_nxt_s;
      valid_r  <= (count_nxt_s != {LW{1'b0}});
    end
  end

  // Sticky overflow; clear has priority over a same-cycle set.
  always_ff @(posedge clk_out or negedge reset_n) begin
    if (!reset_n) begin
      overflow_r <= 1'b0;
    end else if (clear) begin
      overflow_r <= 1'b0;
    end else if (drop_s | mk_lost_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  // Saturating per-bin hit counters, independent of enable and FIFO state.
  always_ff @(posedge clk_out or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NBINS; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else if (clear) begin
      for (int i = 0; i < NBINS; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NBINS; i++) begin
        if (det[i] && (cnt_r[i] != {CNT_W{1'b1}})) begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  // Counter readout mux; selects beyond the last bin read as zero.
  always_comb begin
    sel_cnt_s = {CNT_W{1'b0}};
    for (int i = 0; i < NBINS; i++) begin
      sel_cnt_s = (cnt_sel == 4'(i)) ? cnt_r[i] : sel_cnt_s;
    end
  end

  // Registered counter readout.
  always_ff @(posedge clk_out or negedge reset_n) begin
    if (!reset_n) begin
      cnt_value_r <= {CNT_W{1'b0}};
    end else begin
      cnt_value_r <= sel_cnt_s;
    end
  end

  assign ev_data    = head_r;
  assign ev_valid   = valid_r;
  assign fifo_level = count_r;
  assign overflow   = overflow_r;
  assign cnt_value  = cnt_value_r;

endmodule

// File: tb/tb_det_event_encoder.sv
// Self-checking bench for det_event_encoder: a queue-based reference model
// checks the default-size instance every cycle under directed, table-driven
// and random stimulus; a small instance (TS_W=4, CNT_W=4) covers counter
// saturation, clear priority and timestamp rollover markers.
`timescale 1ns/1ps
module tb_det_event_encoder;
  localparam int NB = 10;
  localparam int TW = 16;
  localparam int FD = 16;
  localparam int CW = 16;
  localparam int EW = TW + 6;

  logic           clk_out = 1'b0;
  logic           reset_n;
  logic [NB-1:0]  det;
  logic           enable, clear, ev_ready;
  logic [3:0]     cnt_sel;
  logic [EW-1:0]  ev_data;
  logic           ev_valid;
  logic [4:0]     fifo_level;
  logic           overflow;
  logic [CW-1:0]  cnt_value;

  logic [NB-1:0]  det_s;
  logic           enable_s, clear_s, ready_s;
  logic [3:0]     sel_s;
  logic [9:0]     data_s;
  logic           valid_s;
  logic [2:0]     level_s;
  logic           ovf_s;
  logic [3:0]     cnt_s;

  always #5 clk_out = ~clk_out;

  det_event_encoder #(.NBINS(NB), .TS_W(TW), .FIFO_DEPTH(FD), .CNT_W(CW)) dut (
    .clk_out(clk_out), .reset_n(reset_n), .det(det), .enable(enable), .clear(clear),
    .ev_data(ev_data), .ev_valid(ev_valid), .ev_ready(ev_ready), .fifo_level(fifo_level),
    .overflow(overflow), .cnt_sel(cnt_sel), .cnt_value(cnt_value));

  det_event_encoder #(.NBINS(NB), .TS_W(4), .FIFO_DEPTH(4), .CNT_W(4)) dut_s (
    .clk_out(clk_out), .reset_n(reset_n), .det(det_s), .enable(enable_s), .clear(clear_s),
    .ev_data(data_s), .ev_valid(valid_s), .ev_ready(ready_s), .fifo_level(level_s),
    .overflow(ovf_s), .cnt_sel(sel_s), .cnt_value(cnt_s));

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (main instance) ----------------
  logic [TW-1:0] m_ts = '0;
  bit            m_s1_v = 1'b0;
  logic [EW-1:0] m_s1_w = '0;
  logic [EW-1:0] m_q[$];
  bit            m_ovf = 1'b0;
  int            m_cnt[NB];
  logic [CW-1:0] m_cval = '0;
  bit            m_pop;
  int            m_sz;
  int            m_bin;

  function automatic logic [EW-1:0] ev_word(input logic [NB-1:0] d, input logic [TW-1:0] t);
    int b;
    b = 0;
    for (int i = 0; i < NB; i++) begin
      if (d[i]) begin
        b = i;
        break;
      end
    end
    return {1'b0, ($countones(d) >= 2), 4'(b), t};
  endfunction

  // Model update on each active edge, then compare all outputs just after it.
  always @(posedge clk_out) begin
    if (!reset_n) begin
      m_ts = '0; m_s1_v = 1'b0; m_q.delete(); m_ovf = 1'b0; m_cval = '0;
      for (int b = 0; b < NB; b++) m_cnt[b] = 0;
    end else begin
      m_sz  = m_q.size();
      m_pop = (m_sz != 0) && ev_ready;
      if (m_pop) void'(m_q.pop_front());
      if (m_s1_v) begin
        if (m_sz < FD || m_pop) m_q.push_back(m_s1_w);
        else m_ovf = 1'b1;
      end
      if (clear) m_ovf = 1'b0;
      m_bin  = int'(cnt_sel);
      m_cval = (m_bin < NB) ? CW'(m_cnt[m_bin]) : '0;
      for (int b = 0; b < NB; b++) begin
        if (clear) m_cnt[b] = 0;
        else if (det[b] && m_cnt[b] < (1 << CW) - 1) m_cnt[b] = m_cnt[b] + 1;
      end
      m_s1_v = enable && (det != '0);
      m_s1_w = ev_word(det, m_ts);
      m_ts   = m_ts + 16'd1;
    end
    #1;
    check("mdl_valid", ev_valid, (m_q.size() != 0));
    check("mdl_data", ev_data, (m_q.size() != 0) ? m_q[0] : '0);
    check("mdl_level", fifo_level, m_q.size());
    check("mdl_ovf", overflow, m_ovf);
    check("mdl_cnt", cnt_value, m_cval);
  end

  // Timestamp tracker for the small instance.
  logic [3:0] s_ts;
  always @(posedge clk_out or negedge reset_n) begin
    if (!reset_n) s_ts <= 4'd0;
    else s_ts <= s_ts + 4'd1;
  end

  typedef struct {
    logic [NB-1:0] det;
    logic [3:0]    bin;
    logic          multi;
  } vec_t;
  vec_t          tbl[6];
  logic [TW-1:0] ts_log[20];
  logic [TW-1:0] exp_ts;
  int            k;

  initial begin
    tbl[0] = '{10'b1000000100, 4'd2, 1'b1};
    tbl[1] = '{10'b0000000001, 4'd0, 1'b0};
    tbl[2] = '{10'b1000000000, 4'd9, 1'b0};
    tbl[3] = '{10'b1111111111, 4'd0, 1'b1};
    tbl[4] = '{10'b0000110000, 4'd4, 1'b1};
    tbl[5] = '{10'b0100000000, 4'd8, 1'b0};

    reset_n = 1'b0; det = '0; enable = 1'b1; clear = 1'b0; ev_ready = 1'b1; cnt_sel = 4'd0;
    det_s = '0; enable_s = 1'b1; clear_s = 1'b0; ready_s = 1'b1; sel_s = 4'd0;
    repeat (3) @(negedge clk_out);
    check("rst_valid", ev_valid, 1'b0);
    check("rst_data", ev_data, '0);
    check("rst_level", fifo_level, 5'd0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_cnt", cnt_value, '0);
    check("rst_valid_s", valid_s, 1'b0);
    reset_n = 1'b1;

    // Single hit at timestamp 5: visible two cycles later.
    k = 0;
    while (m_ts != 16'd5 && k < 50) begin @(negedge clk_out); k++; end
    check("ts_reach5", m_ts, 16'd5);
    det = 10'b0000001000;
    @(negedge clk_out); det = '0;
    check("lat_n1_valid", ev_valid, 1'b0);
    @(negedge clk_out);
    check("lat_n2_valid", ev_valid, 1'b1);
    check("single_word", ev_data, {1'b0, 1'b0, 4'd3, 16'h0005});
    check("single_lvl1", fifo_level, 5'd1);
    @(negedge clk_out);
    check("single_lvl0", fifo_level, 5'd0);

    // Table of patterns; the first is the multi-hit case with counter readout.
    clear = 1'b1; @(negedge clk_out); clear = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp_ts = m_ts;
      det = tbl[i].det;
      @(negedge clk_out); det = '0;
      @(negedge clk_out);
      check("tbl_word", ev_data, {1'b0, tbl[i].multi, tbl[i].bin, exp_ts});
      if (i == 0) begin
        cnt_sel = 4'd2; @(negedge clk_out);
        check("multi_cnt2", cnt_value, 16'd1);
        cnt_sel = 4'd9; @(negedge clk_out);
        check("multi_cnt9", cnt_value, 16'd1);
      end
      @(negedge clk_out);
    end

    // Backpressure: 17 events into a 16-deep FIFO.
    clear = 1'b1; @(negedge clk_out); clear = 1'b0;
    ev_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      ts_log[i] = m_ts;
      det = NB'(1 << (i % 10));
      @(negedge clk_out);
    end
    det = '0;
    repeat (3) @(negedge clk_out);
    check("bp_level", fifo_level, 5'd16);
    check("bp_ovf", overflow, 1'b1);
    for (int b = 0; b < NB; b++) begin
      cnt_sel = 4'(b); @(negedge clk_out);
      check("bp_bin_cnt", cnt_value, (b < 7) ? 16'd2 : 16'd1);
    end
    clear = 1'b1; @(negedge clk_out); clear = 1'b0;
    check("clr_ovf", overflow, 1'b0);
    @(negedge clk_out);
    check("clr_cnt9", cnt_value, 16'd0);
    cnt_sel = 4'd0; @(negedge clk_out);
    check("clr_cnt0", cnt_value, 16'd0);
    check("clr_keeps_fifo", fifo_level, 5'd16);
    ev_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_word", ev_data, {2'b00, 4'(i % 10), ts_log[i]});
      @(negedge clk_out);
    end
    check("drain_empty", ev_valid, 1'b0);

    // Full FIFO with a push and pop in the same cycle.
    ev_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      ts_log[i] = m_ts;
      det = (i < 16) ? NB'(1 << (i % 10)) : 10'b0000010000;
      if (i == 16) begin
        @(negedge clk_out); det = '0; ev_ready = 1'b1;
        @(negedge clk_out); ev_ready = 1'b0;
      end else begin
        @(negedge clk_out); det = '0;
        if (i == 15) repeat (3) @(negedge clk_out);
      end
    end
    check("pp_level", fifo_level, 5'd16);
    check("pp_ovf", overflow, 1'b0);
    ev_ready = 1'b1;
    for (int i = 1; i < 17; i++) begin
      check("pp_word", ev_data, {2'b00, (i == 16) ? 4'd4 : 4'(i % 10), ts_log[i]});
      @(negedge clk_out);
    end
    check("pp_empty", ev_valid, 1'b0);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      det      = ($urandom_range(0, 2) == 0) ? NB'($urandom) : '0;
      enable   = ($urandom_range(0, 7) != 0);
      clear    = ($urandom_range(0, 63) == 0);
      ev_ready = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cnt_sel  = 4'($urandom_range(0, 15));
      @(negedge clk_out);
    end
    det = '0; enable = 1'b1; clear = 1'b0; ev_ready = 1'b1;
    repeat (20) @(negedge clk_out);

    // Small instance: saturation and clear priority.
    sel_s = 4'd0;
    clear_s = 1'b1; @(negedge clk_out); clear_s = 1'b0;
    det_s = 10'b0000000001;
    repeat (20) @(negedge clk_out);
    det_s = '0;
    repeat (2) @(negedge clk_out);
    check("sat_cnt", cnt_s, 4'd15);
    det_s = 10'b0000000001; clear_s = 1'b1;
    @(negedge clk_out); det_s = '0; clear_s = 1'b0;
    check("clr_lag_cnt", cnt_s, 4'd15);
    @(negedge clk_out);
    check("clr_prio_cnt", cnt_s, 4'd0);
    @(negedge clk_out);
    check("clr_ovf_s", ovf_s, 1'b0);

    // Small instance: event sampled in the last cycle before rollover.
    repeat (4) @(negedge clk_out);
    k = 0;
    while (s_ts != 4'hF && k < 40) begin @(negedge clk_out); k++; end
    check("ts_reachF", s_ts, 4'hF);
    det_s = 10'b0000000010;
    @(negedge clk_out); det_s = '0;
    @(negedge clk_out);
    check("wrap_ev_valid", valid_s, 1'b1);
    check("wrap_ev_word", data_s, {1'b0, 1'b0, 4'd1, 4'hF});
    check("wrap_ev_level", level_s, 3'd1);
    @(negedge clk_out);
`ifdef DET_EVENT_ROLLOVER_MARKER_EN
    check("marker_valid", valid_s, 1'b1);
    check("marker_word", data_s, {1'b1, 1'b0, 4'hF, 4'h0});
`else
    check("no_marker", valid_s, 1'b0);
`endif

    // Asynchronous reset with a partly filled FIFO.
    ev_ready = 1'b0;
    det = 10'b0000000100; repeat (3) @(negedge clk_out); det = '0;
    repeat (3) @(negedge clk_out);
    check("pre_rst_level", fifo_level, 5'd3);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", ev_valid, 1'b0);
    check("arst_level", fifo_level, 5'd0);
    check("arst_data", ev_data, '0);
    @(negedge clk_out); @(negedge clk_out);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_out);
    check("post_rst_valid", ev_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
